// File: rtl/branch_unit.sv
// -----------------------------------------------------------------------------
// branch_unit
//
// Branch resolution and program-counter unit for the single-cycle datapath.
// Holds the PC and a registered ALU flag set {Z,N,C,V}. It decodes an
// eight-way condition code and selects the next PC from three sources:
// sequential (pc+1), PC-relative (pc+offset) or register-indirect
// (reg_target). It also provides stall control, a registered redirect pulse
// that fetch uses for flushing, and a saturating taken-branch counter.
//
// Optional feature macro: FLAG_BYPASS_EN
//   When this macro is defined and flag_we=1, the condition is evaluated on
//   {z_in,n_in,c_in,v_in} in the same cycle, so one instruction can compare
//   and branch. When it is undefined, the condition always uses the
//   registered flags.
//
// Parameters
//   PC_W      PC / target width (>= 4)
//   OFF_W     signed offset width (<= PC_W)
//   CNT_W     taken-branch counter width
//   RESET_PC  PC value loaded on reset
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   en           advance enable (0 = stall, all state held)
//   flag_we      load z_in/n_in/c_in/v_in into the flag register
//   z_in..v_in   ALU flags of the current instruction
//   branch       unconditional branch
//   branch_if    conditional branch, qualified by cond
//   cond         condition select (EQ NE LT GE MI PL CS AL)
//   jump_reg     taken target is reg_target instead of PC-relative
//   offset       signed PC-relative displacement
//   reg_target   absolute target for register-indirect branches
//   pc           current program counter
//   taken        combinational branch-taken decision
//   redirect     registered: a taken branch retired on the previous edge
//   flags        registered {Z,N,C,V}
//   taken_count  saturating count of taken branches
// -----------------------------------------------------------------------------
module branch_unit #(
  parameter int PC_W     = 8,
  parameter int OFF_W    = 8,
  parameter int CNT_W    = 16,
  parameter int RESET_PC = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flag_we,
  input  logic             z_in,
  input  logic             n_in,
  input  logic             c_in,
  input  logic             v_in,
  input  logic             branch,
  input  logic             branch_if,
  input  logic [2:0]       cond,
  input  logic             jump_reg,
  input  logic [OFF_W-1:0] offset,
  input  logic [PC_W-1:0]  reg_target,
  output logic [PC_W-1:0]  pc,
  output logic             taken,
  output logic             redirect,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] taken_count
);

  logic [PC_W-1:0]  pc_reg;
  logic [PC_W-1:0]  pc_next;
  logic [3:0]       flags_reg;
  logic             redirect_reg;
  logic [CNT_W-1:0] count_reg;
  logic [3:0]       flag_src;
  logic             cond_true;
  logic [PC_W-1:0]  offset_ext;

  // Condition source. With the bypass enabled, a flag write in the same
  // cycle feeds the decoder directly. The flags output still shows only the
  // registered value.
`ifdef FLAG_BYPASS_EN
  assign flag_src = flag_we ? {z_in, n_in, c_in, v_in} : flags_reg;
`else
  assign flag_src = flags_reg;
`endif

  // flag_src bit order: [3]=Z [2]=N [1]=C [0]=V
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'b000:  cond_true = flag_src[3];                    // EQ
      3'b001:  cond_true = ~flag_src[3];                   // NE
      3'b010:  cond_true = flag_src[2] ^ flag_src[0];      // LT
      3'b011:  cond_true = ~(flag_src[2] ^ flag_src[0]);   // GE
      3'b100:  cond_true = flag_src[2];                    // MI
      3'b101:  cond_true = ~flag_src[2];                   // PL
      3'b110:  cond_true = flag_src[1];                    // CS
      default: cond_true = 1'b1;                           // AL
    endcase
  end

  assign taken = branch | (branch_if & cond_true);

  // Sign-extend the offset to PC width. The addition then wraps modulo
  // 2^PC_W, which gives the silent wrap-around in both directions.
  assign offset_ext = PC_W'($signed(offset));

  always_comb begin
    pc_next = pc_reg + PC_W'(1);
    if (taken) begin
      if (jump_reg) pc_next = reg_target;
      else          pc_next = pc_reg + offset_ext;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg       <= PC_W'(RESET_PC);
      flags_reg    <= 4'b0000;
      redirect_reg <= 1'b0;
      count_reg    <= '0;
    end else begin
      // redirect updates on every edge, so it drops during a stall
      redirect_reg <= en & taken;
      if (en) begin
        pc_reg <= pc_next;
        if (flag_we) flags_reg <= {z_in, n_in, c_in, v_in};
        if (taken && (count_reg != {CNT_W{1'b1}}))
          count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  assign pc          = pc_reg;
  assign redirect    = redirect_reg;
  assign flags       = flags_reg;
  assign taken_count = count_reg;

endmodule

// File: tb/tb_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_unit
//
// Self-checking bench for branch_unit. A reference model runs alongside the
// DUT. When stimulus is driven, the model's expected post-edge state is
// pushed to a scoreboard queue. Each test task pops that entry once the edge
// has happened and compares it with the DUT. A second instance with CNT_W=2
// shares the same inputs and is used to check counter saturation.
// -----------------------------------------------------------------------------
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, flag_we, z_in, n_in, c_in, v_in;
  logic        branch, branch_if, jump_reg;
  logic [2:0]  cond;
  logic [7:0]  offset, reg_target;
  logic [7:0]  pc, pc2;
  logic        taken, taken2, redirect, redirect2;
  logic [3:0]  flags, flags2;
  logic [15:0] taken_count;
  logic [1:0]  cnt2;

  branch_unit dut (
    .clk(clk), .reset(reset), .en(en), .flag_we(flag_we),
    .z_in(z_in), .n_in(n_in), .c_in(c_in), .v_in(v_in),
    .branch(branch), .branch_if(branch_if), .cond(cond), .jump_reg(jump_reg),
    .offset(offset), .reg_target(reg_target), .pc(pc), .taken(taken),
    .redirect(redirect), .flags(flags), .taken_count(taken_count)
  );

  branch_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .flag_we(flag_we),
    .z_in(z_in), .n_in(n_in), .c_in(c_in), .v_in(v_in),
    .branch(branch), .branch_if(branch_if), .cond(cond), .jump_reg(jump_reg),
    .offset(offset), .reg_target(reg_target), .pc(pc2), .taken(taken2),
    .redirect(redirect2), .flags(flags2), .taken_count(cnt2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pc;
    logic [3:0]  flags;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    logic        redir;
    logic        tk;      // model taken decision
    logic        tk_obs;  // DUT taken sampled before the edge
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0]  m_pc;
  logic [3:0]  m_flags;
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt2;
  logic        m_redir;

  task automatic model_reset();
    m_pc = 8'h00; m_flags = 4'h0; m_cnt = 16'h0; m_cnt2 = 2'd0; m_redir = 1'b0;
  endtask

  task automatic idle_inputs();
    en = 0; flag_we = 0; {z_in, n_in, c_in, v_in} = 4'h0; branch = 0;
    branch_if = 0; cond = 3'd0; jump_reg = 0; offset = 8'h00; reg_target = 8'h00;
  endtask

  // Drive one cycle of stimulus at the negedge, run the model, and (when rec)
  // push the expected post-edge state. Returns #1 after the next posedge.
  task automatic apply(input bit rec, input bit e, input bit fwe, input logic [3:0] fin,
                       input bit b, input bit bi, input logic [2:0] c, input bit jr,
                       input logic [7:0] off, input logic [7:0] rt);
    exp_t x;
    logic [3:0] f;
    logic ct, tk;
    @(negedge clk);
    en = e; flag_we = fwe; {z_in, n_in, c_in, v_in} = fin; branch = b;
    branch_if = bi; cond = c; jump_reg = jr; offset = off; reg_target = rt;
    #1;
    f = m_flags;
`ifdef FLAG_BYPASS_EN
    if (fwe) f = fin;
`endif
    case (c)
      3'd0: ct = f[3];
      3'd1: ct = ~f[3];
      3'd2: ct = f[2] ^ f[0];
      3'd3: ct = ~(f[2] ^ f[0]);
      3'd4: ct = f[2];
      3'd5: ct = ~f[2];
      3'd6: ct = f[1];
      default: ct = 1'b1;
    endcase
    tk = b | (bi & ct);
    x.tk = tk;
    x.tk_obs = taken;
    if (e) begin
      m_pc = tk ? (jr ? rt : m_pc + off) : m_pc + 8'd1;
      if (fwe) m_flags = fin;
      if (tk && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (tk && m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
    end
    m_redir = e & tk;
    x.pc = m_pc; x.flags = m_flags; x.cnt = m_cnt; x.cnt2 = m_cnt2; x.redir = m_redir;
    if (rec) sb.push_back(x);
    @(posedge clk);
    #1;
    $display("txn en=%0b fwe=%0b b=%0b bi=%0b cond=%0d jr=%0b off=%02h rt=%02h -> pc=%02h taken=%0b redir=%0b flags=%04b cnt=%0d",
             e, fwe, b, bi, c, jr, off, rt, pc, x.tk_obs, redirect, flags, taken_count);
  endtask

  task automatic test_reset();
    exp_t x;
    apply(1, 1, 0, 4'h0, 1, 0, 3'd0, 1, 8'h00, 8'h37);
    x = sb.pop_front();
    checks++;
    if (pc !== 8'h37 || redirect !== x.redir || taken_count !== x.cnt) begin
      errors++; $display("FAIL reset_setup: pc=%02h redir=%0b cnt=%0d want pc=37 redir=%0b cnt=%0d", pc, redirect, taken_count, x.redir, x.cnt);
    end
    // assert reset mid-cycle and check outputs change without a clock edge
    #2 reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (pc !== 8'h00 || flags !== 4'h0 || taken_count !== 16'h0 || redirect !== 1'b0) begin
      errors++; $display("FAIL reset_async: pc=%02h flags=%04b cnt=%0d redir=%0b want 00/0000/0/0", pc, flags, taken_count, redirect);
    end
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply(1, 1, 0, 4'h0, 0, 0, 3'd0, 0, 8'h00, 8'h00);
      x = sb.pop_front();
      checks++;
      if (pc !== x.pc || redirect !== x.redir) begin
        errors++; $display("FAIL reset_seq%0d: pc=%02h redir=%0b want pc=%02h redir=%0b", i, pc, redirect, x.pc, x.redir);
      end
    end
    checks++;
    if (pc !== 8'h03) begin
      errors++; $display("FAIL reset_release: pc=%02h want 03", pc);
    end
  endtask

  task automatic test_conditions();
    exp_t x;
    logic [7:0] tbl;
    // With {Z,N,C,V}=0101 the taken conditions are NE, GE, MI and AL.
    tbl = 8'b1001_1010;
    apply(0, 1, 1, 4'b0101, 0, 0, 3'd0, 0, 8'h00, 8'h00);
    for (int c = 0; c < 8; c++) begin
      apply(0, 1, 0, 4'h0, 1, 0, 3'd0, 1, 8'h00, 8'h10);
      apply(1, 1, 0, 4'h0, 0, 1, 3'(c), 0, 8'h04, 8'h00);
      x = sb.pop_front();
      checks++;
      if (x.tk_obs !== tbl[c] || pc !== (tbl[c] ? 8'h14 : 8'h11) || taken_count !== x.cnt) begin
        errors++; $display("FAIL cond%0d: taken=%0b pc=%02h cnt=%0d want taken=%0b pc=%02h cnt=%0d",
                           c, x.tk_obs, pc, taken_count, tbl[c], tbl[c] ? 8'h14 : 8'h11, x.cnt);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t x;
    apply(0, 1, 0, 4'h0, 1, 0, 3'd0, 1, 8'h00, 8'hFE);
    apply(1, 1, 0, 4'h0, 1, 0, 3'd0, 0, 8'h03, 8'h00);
    x = sb.pop_front();
    checks++;
    if (pc !== 8'h01 || pc !== x.pc) begin
      errors++; $display("FAIL wrap_up: pc=%02h want 01", pc);
    end
    apply(0, 1, 0, 4'h0, 1, 0, 3'd0, 1, 8'h00, 8'h00);
    apply(1, 1, 0, 4'h0, 1, 0, 3'd0, 0, 8'hFF, 8'h00);
    x = sb.pop_front();
    checks++;
    if (pc !== 8'hFF || pc !== x.pc) begin
      errors++; $display("FAIL wrap_down: pc=%02h want FF", pc);
    end
  endtask

  task automatic test_stall();
    exp_t x;
    logic [7:0]  pc0;
    logic [3:0]  f0;
    logic [15:0] c0;
    pc0 = m_pc; f0 = m_flags; c0 = m_cnt;
    for (int i = 0; i < 2; i++) begin
      apply(1, 0, 1, 4'b1111, 1, 0, 3'd0, 0, 8'h02, 8'h00);
      x = sb.pop_front();
      checks++;
      if (pc !== pc0 || flags !== f0 || taken_count !== c0 || redirect !== 1'b0 || x.tk_obs !== 1'b1) begin
        errors++; $display("FAIL stall%0d: pc=%02h flags=%04b cnt=%0d redir=%0b taken=%0b want %02h/%04b/%0d/0/1",
                           i, pc, flags, taken_count, redirect, x.tk_obs, pc0, f0, c0);
      end
    end
    apply(1, 1, 0, 4'h0, 1, 0, 3'd0, 0, 8'h02, 8'h00);
    x = sb.pop_front();
    checks++;
    if (redirect !== 1'b1 || pc !== pc0 + 8'h02 || taken_count !== c0 + 16'd1) begin
      errors++; $display("FAIL stall_resume: redir=%0b pc=%02h cnt=%0d want 1/%02h/%0d", redirect, pc, taken_count, pc0 + 8'h02, c0 + 16'd1);
    end
    apply(1, 1, 0, 4'h0, 0, 0, 3'd0, 0, 8'h00, 8'h00);
    x = sb.pop_front();
    checks++;
    if (redirect !== 1'b0 || pc !== x.pc) begin
      errors++; $display("FAIL stall_pulse_end: redir=%0b pc=%02h want 0/%02h", redirect, pc, x.pc);
    end
  endtask

  task automatic test_jump_priority();
    exp_t x;
    logic [15:0] c0;
    apply(0, 1, 1, 4'b0101, 0, 0, 3'd0, 0, 8'h00, 8'h00); // Z=0 so EQ is false
    c0 = m_cnt;
    apply(1, 1, 0, 4'h0, 1, 1, 3'd0, 1, 8'h04, 8'hA5);
    x = sb.pop_front();
    checks++;
    if (pc !== 8'hA5 || taken_count !== c0 + 16'd1 || redirect !== 1'b1) begin
      errors++; $display("FAIL jump_reg: pc=%02h cnt=%0d redir=%0b want A5/%0d/1", pc, taken_count, redirect, c0 + 16'd1);
    end
    // jump_reg has no effect when nothing is taken
    apply(1, 1, 0, 4'h0, 0, 1, 3'd0, 1, 8'h04, 8'h33);
    x = sb.pop_front();
    checks++;
    if (pc !== 8'hA6 || x.tk_obs !== 1'b0) begin
      errors++; $display("FAIL jump_reg_ignored: pc=%02h taken=%0b want A6/0", pc, x.tk_obs);
    end
  endtask

  task automatic test_same_cycle_flags();
    exp_t x;
    logic [7:0] pc0, want;
    apply(0, 1, 1, 4'b0000, 0, 0, 3'd0, 0, 8'h00, 8'h00);
    pc0 = m_pc;
`ifdef FLAG_BYPASS_EN
    want = pc0 + 8'h04;
`else
    want = pc0 + 8'h01;
`endif
    apply(1, 1, 1, 4'b1000, 0, 1, 3'd0, 0, 8'h04, 8'h00);
    x = sb.pop_front();
    checks++;
    if (pc !== want || flags !== 4'b1000) begin
      errors++; $display("FAIL same_cycle_flag: pc=%02h flags=%04b want %02h/1000", pc, flags, want);
    end
    // the new Z now applies
    apply(1, 1, 0, 4'h0, 0, 1, 3'd0, 0, 8'h04, 8'h00);
    x = sb.pop_front();
    checks++;
    if (pc !== want + 8'h04 || x.tk_obs !== 1'b1) begin
      errors++; $display("FAIL flag_next_cycle: pc=%02h taken=%0b want %02h/1", pc, x.tk_obs, want + 8'h04);
    end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    for (int i = 0; i < 3; i++) begin
      apply(1, 1, 0, 4'h0, 0, 1, 3'd7, 0, 8'h10, 8'h00);
      x = sb.pop_front();
      checks++;
      if (redirect !== 1'b1 || pc !== x.pc || taken_count !== x.cnt) begin
        errors++; $display("FAIL b2b%0d: redir=%0b pc=%02h cnt=%0d want 1/%02h/%0d", i, redirect, pc, taken_count, x.pc, x.cnt);
      end
    end
  endtask

  task automatic test_saturation();
    exp_t x;
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #2;
    model_reset();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      apply(1, 1, 0, 4'h0, 1, 0, 3'd0, 0, 8'h01, 8'h00);
      x = sb.pop_front();
      checks++;
      if (cnt2 !== ((i < 3) ? 2'(i + 1) : 2'd3) || taken_count !== 16'(i + 1) ||
          pc2 !== x.pc || flags2 !== x.flags || redirect2 !== x.redir || taken2 !== 1'b1) begin
        errors++; $display("FAIL saturate%0d: cnt2=%0d cnt=%0d pc2=%02h want cnt2=%0d cnt=%0d pc2=%02h",
                           i, cnt2, taken_count, pc2, (i < 3) ? i + 1 : 3, i + 1, x.pc);
      end
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_conditions();
    test_wrap();
    test_stall();
    test_jump_priority();
    test_same_cycle_flags();
    test_back_to_back();
    test_saturation();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
